// File: rtl/map_pkg.sv
// Shared definitions for the sprite map writer: tile codes, map defaults, FSM states.
package map_pkg;

    localparam int MAP_W_DEF  = 40;
    localparam int MAP_H_DEF  = 30;
    localparam int CODE_W_DEF = 4;

    typedef enum logic [CODE_W_DEF-1:0] {
        EMPTY  = 4'd0,
        WALL   = 4'd1,
        PILL   = 4'd2,
        PACMAN = 4'd3,
        GHOST  = 4'd4,
        POWER  = 4'd5
    } tile_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_OLD,
        WT_OLD,
        WR_OLD,
        RD_NEW,
        WT_NEW,
        WR_NEW,
        DONE
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant; the pointer moves just past the winner on advance.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int P_W = (N > 1) ? $clog2(N) : 1;

    logic [P_W-1:0] ptr;
    logic [P_W-1:0] grant_idx;
    logic           found;

    // First requester at or above the pointer wins; otherwise wrap to the lowest requester.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j >= int'(ptr))) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = P_W'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = P_W'(j);
            end
        end
    end

    // Pointer register: channel after the last winner gets top priority next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (grant_idx == P_W'(N - 1)) ? '0 : grant_idx + P_W'(1);
        end
    end

endmodule

// File: rtl/sprite_map_writer.sv
// Moves sprites on a row-organised tile map: restores the tile under the sprite at its
// old position, then places the sprite code at the new position, remembering what it covered.
//
// state  | meaning
// IDLE   | waiting for a move request; grants one channel
// RD_OLD | address the old row
// WT_OLD | read data arrives; build old-row write data
// WR_OLD | write old row with the shadow tile restored
// RD_NEW | address the new row (re-read so a same-row write is seen)
// WT_NEW | read data arrives; build new-row write data, keep covered tile
// WR_NEW | write new row with the sprite code; covered tile becomes shadow
// DONE   | ack pulse (with error flag if rejected)
module sprite_map_writer
    import map_pkg::*;
#(
    parameter int N_SPR   = 4,
    parameter int MAP_W   = MAP_W_DEF,
    parameter int MAP_H   = MAP_H_DEF,
    parameter int CODE_W  = CODE_W_DEF,
    localparam int ROW_W  = MAP_W * CODE_W,
    localparam int X_W    = $clog2(MAP_W),
    localparam int Y_W    = $clog2(MAP_H)
) (
    input  logic                    CLOCK_50,
    input  logic                    reset_n,
    input  logic [N_SPR-1:0]        mv_req,
    input  logic [N_SPR*X_W-1:0]    cur_x,
    input  logic [N_SPR*X_W-1:0]    nxt_x,
    input  logic [N_SPR*Y_W-1:0]    cur_y,
    input  logic [N_SPR*Y_W-1:0]    nxt_y,
    input  logic [N_SPR*CODE_W-1:0] spr_code,
    output logic [N_SPR-1:0]        mv_ack,
    output logic                    mv_err,
    output logic [Y_W-1:0]          ram_addr,
    output logic [ROW_W-1:0]        ram_wdata,
    output logic                    ram_wren,
    input  logic [ROW_W-1:0]        ram_rdata,
    output logic                    busy
);

    localparam int CH_W  = (N_SPR > 1) ? $clog2(N_SPR) : 1;
    localparam int IDX_W = $clog2(ROW_W);

    state_e state, state_next;

    logic [N_SPR-1:0]  grant;
    logic              advance;
    logic [CH_W-1:0]   g_idx;
    logic [X_W-1:0]    g_cur_x, g_nxt_x;
    logic [Y_W-1:0]    g_cur_y, g_nxt_y;
    logic [CODE_W-1:0] g_code;
    logic              req_bad, req_same;

    logic [CH_W-1:0]   ch_q;
    logic [X_W-1:0]    cur_x_q, nxt_x_q;
    logic [Y_W-1:0]    nxt_y_q;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] old_tile_q;
    logic              err_q;
    logic [CODE_W-1:0] shadow [N_SPR];

    // Column 0 sits at the row MSBs.
    function automatic logic [IDX_W-1:0] tile_hi(input logic [X_W-1:0] x);
        return IDX_W'(ROW_W - 1 - CODE_W * int'(x));
    endfunction

    function automatic logic [ROW_W-1:0] put_tile(input logic [ROW_W-1:0]  row,
                                                  input logic [X_W-1:0]    x,
                                                  input logic [CODE_W-1:0] code);
        logic [ROW_W-1:0] r;
        r = row;
        r[tile_hi(x) -: CODE_W] = code;
        return r;
    endfunction

    function automatic logic [CODE_W-1:0] get_tile(input logic [ROW_W-1:0] row,
                                                   input logic [X_W-1:0]   x);
        return row[tile_hi(x) -: CODE_W];
    endfunction

    assign advance = (state == IDLE) && (|mv_req);

    rr_arbiter #(.N(N_SPR)) u_arb (
        .clk     (CLOCK_50),
        .rst_n   (reset_n),
        .req     (mv_req),
        .advance (advance),
        .grant   (grant)
    );

    // Select the granted channel's request fields and classify the move.
    always_comb begin
        g_idx   = '0;
        g_cur_x = '0;
        g_nxt_x = '0;
        g_cur_y = '0;
        g_nxt_y = '0;
        g_code  = '0;
        for (int i = 0; i < N_SPR; i++) begin
            if (grant[i]) begin
                g_idx   = CH_W'(i);
                g_cur_x = cur_x[i*X_W +: X_W];
                g_nxt_x = nxt_x[i*X_W +: X_W];
                g_cur_y = cur_y[i*Y_W +: Y_W];
                g_nxt_y = nxt_y[i*Y_W +: Y_W];
                g_code  = spr_code[i*CODE_W +: CODE_W];
            end
        end
        req_bad  = (int'(g_cur_x) >= MAP_W) || (int'(g_nxt_x) >= MAP_W) ||
                   (int'(g_cur_y) >= MAP_H) || (int'(g_nxt_y) >= MAP_H);
        req_same = (g_cur_x == g_nxt_x) && (g_cur_y == g_nxt_y);
    end

    // State register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next = state;
        mv_ack     = '0;
        mv_err     = 1'b0;
        ram_wren   = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (advance) state_next = (req_bad || req_same) ? DONE : RD_OLD;
            RD_OLD:  state_next = WT_OLD;
            WT_OLD:  state_next = WR_OLD;
            WR_OLD:  begin state_next = RD_NEW; ram_wren = 1'b1; end
            RD_NEW:  state_next = WT_NEW;
            WT_NEW:  state_next = WR_NEW;
            WR_NEW:  begin state_next = DONE; ram_wren = 1'b1; end
            DONE: begin
                state_next = IDLE;
                mv_err     = err_q;
                for (int i = 0; i < N_SPR; i++) mv_ack[i] = (ch_q == CH_W'(i));
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch, RAM address/data registers and per-channel shadow tiles.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            ch_q       <= '0;
            cur_x_q    <= '0;
            nxt_x_q    <= '0;
            nxt_y_q    <= '0;
            code_q     <= '0;
            old_tile_q <= '0;
            err_q      <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            for (int i = 0; i < N_SPR; i++) shadow[i] <= CODE_W'(EMPTY);
        end else begin
            case (state)
                IDLE: if (advance) begin
                    ch_q    <= g_idx;
                    cur_x_q <= g_cur_x;
                    nxt_x_q <= g_nxt_x;
                    nxt_y_q <= g_nxt_y;
                    code_q  <= g_code;
                    err_q   <= req_bad;
                    if (!(req_bad || req_same)) ram_addr <= g_cur_y;
                end
                WT_OLD: ram_wdata <= put_tile(ram_rdata, cur_x_q, shadow[ch_q]);
                WR_OLD: ram_addr  <= nxt_y_q;
                WT_NEW: begin
                    ram_wdata  <= put_tile(ram_rdata, nxt_x_q, code_q);
                    old_tile_q <= get_tile(ram_rdata, nxt_x_q);
                end
                WR_NEW: shadow[ch_q] <= old_tile_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_map_writer.sv
// Bench for sprite_map_writer: RAM model plus a tile-level map/shadow/round-robin reference.
module tb_sprite_map_writer;
    import map_pkg::*;

    localparam int N  = 4;
    localparam int MW = 40;
    localparam int MH = 30;
    localparam int CW = 4;
    localparam int RW = MW * CW;
    localparam int XW = 6;
    localparam int YW = 5;

    logic          CLOCK_50 = 1'b0;
    logic          reset_n  = 1'b0;
    logic [N-1:0]  mv_req   = '0;
    logic [N*XW-1:0] cur_x = '0, nxt_x = '0;
    logic [N*YW-1:0] cur_y = '0, nxt_y = '0;
    logic [N*CW-1:0] spr_code = '0;
    logic [N-1:0]  mv_ack;
    logic          mv_err;
    logic [YW-1:0] ram_addr;
    logic [RW-1:0] ram_wdata;
    logic          ram_wren;
    logic [RW-1:0] ram_rdata = '0;
    logic          busy;

    sprite_map_writer dut (
        .CLOCK_50 (CLOCK_50), .reset_n (reset_n), .mv_req (mv_req),
        .cur_x (cur_x), .nxt_x (nxt_x), .cur_y (cur_y), .nxt_y (nxt_y),
        .spr_code (spr_code), .mv_ack (mv_ack), .mv_err (mv_err),
        .ram_addr (ram_addr), .ram_wdata (ram_wdata), .ram_wren (ram_wren),
        .ram_rdata (ram_rdata), .busy (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // reference model state
    int mdl_map [MH][MW];
    int mdl_shadow [N];
    int mdl_rr = 0;
    int ch_cx [N], ch_cy [N], ch_nx [N], ch_ny [N], ch_code [N];
    int exp_ch [$], exp_err [$], exp_lat [$];
    int exp_writes;
    int obs_ch [$], obs_err [$], obs_lat [$], obs_cyc [$];
    int batch_writes, multi_ack, stray_err;
    bit timeout;

    int n_checks = 0;
    int n_pass   = 0;

    logic [RW-1:0] mem [MH];
    logic load_mem = 1'b0;
    int wr_count = 0;

    function automatic logic [RW-1:0] pack_row(input int y);
        logic [RW-1:0] r = '0;
        for (int x = 0; x < MW; x++) r = (r << CW) | RW'(mdl_map[y][x]);
        return r;
    endfunction

    // Row RAM, one-cycle read latency, read-before-write.
    always @(posedge CLOCK_50) begin
        if (load_mem) begin
            for (int y = 0; y < MH; y++) mem[y] <= pack_row(y);
        end else if (ram_wren) begin
            if (int'(ram_addr) < MH) mem[ram_addr] <= ram_wdata;
            wr_count <= wr_count + 1;
        end
        ram_rdata <= (int'(ram_addr) < MH) ? mem[ram_addr] : '0;
    end

    function automatic int tile_at(input int y, input int x);
        logic [RW-1:0] row;
        row = mem[y] >> (RW - CW * (x + 1));
        return int'(row[CW-1:0]);
    endfunction

    function automatic int map_diff();
        int d = 0;
        for (int y = 0; y < MH; y++)
            for (int x = 0; x < MW; x++)
                if (tile_at(y, x) != mdl_map[y][x]) d++;
        return d;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) mdl_shadow[i] = int'(EMPTY);
        mdl_rr = 0;
    endfunction

    // Grant order and map effect of a set of simultaneously held requests.
    function automatic void model_batch(input logic [N-1:0] mask);
        logic [N-1:0] pend = mask;
        exp_ch.delete(); exp_err.delete(); exp_lat.delete();
        exp_writes = 0;
        while (pend != '0) begin
            int g = -1;
            bit bad, same;
            for (int k = 0; k < N; k++) begin
                int c = (mdl_rr + k) % N;
                if (g < 0 && pend[c]) g = c;
            end
            pend[g] = 1'b0;
            mdl_rr  = (g + 1) % N;
            bad  = ch_cx[g] >= MW || ch_nx[g] >= MW || ch_cy[g] >= MH || ch_ny[g] >= MH;
            same = ch_cx[g] == ch_nx[g] && ch_cy[g] == ch_ny[g];
            exp_ch.push_back(g);
            exp_err.push_back(int'(bad));
            exp_lat.push_back((bad || same) ? 1 : 7);
            if (!bad && !same) begin
                int old;
                mdl_map[ch_cy[g]][ch_cx[g]] = mdl_shadow[g];
                old = mdl_map[ch_ny[g]][ch_nx[g]];
                mdl_map[ch_ny[g]][ch_nx[g]] = ch_code[g];
                mdl_shadow[g] = old;
                exp_writes += 2;
            end
        end
    endfunction

    task automatic drive_inputs();
        cur_x    = {XW'(ch_cx[3]), XW'(ch_cx[2]), XW'(ch_cx[1]), XW'(ch_cx[0])};
        nxt_x    = {XW'(ch_nx[3]), XW'(ch_nx[2]), XW'(ch_nx[1]), XW'(ch_nx[0])};
        cur_y    = {YW'(ch_cy[3]), YW'(ch_cy[2]), YW'(ch_cy[1]), YW'(ch_cy[0])};
        nxt_y    = {YW'(ch_ny[3]), YW'(ch_ny[2]), YW'(ch_ny[1]), YW'(ch_ny[0])};
        spr_code = {CW'(ch_code[3]), CW'(ch_code[2]), CW'(ch_code[1]), CW'(ch_code[0])};
    endtask

    task automatic set_ch(input int c, input int cx, input int cy, input int nx, input int ny, input int code);
        ch_cx[c] = cx; ch_cy[c] = cy; ch_nx[c] = nx; ch_ny[c] = ny; ch_code[c] = code;
    endtask

    task automatic reload();
        @(negedge CLOCK_50); load_mem = 1'b1;
        @(negedge CLOCK_50); load_mem = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50); reset_n = 1'b0; mv_req = '0; model_reset();
        @(negedge CLOCK_50); reset_n = 1'b1;
    endtask

    // Hold the requests, drop each channel on its ack, record what the DUT did.
    task automatic run_batch(input logic [N-1:0] mask, input int budget);
        int got = 0, cyc = 0, lat = 0, w0, target;
        logic prev_busy;
        obs_ch.delete(); obs_err.delete(); obs_lat.delete(); obs_cyc.delete();
        multi_ack = 0; stray_err = 0;
        target = $countones(mask);
        w0 = wr_count;
        drive_inputs();
        mv_req = mask;
        prev_busy = busy;
        while (got < target && cyc < budget) begin
            @(negedge CLOCK_50);
            cyc++;
            if (busy && !prev_busy) lat = 0;
            if (busy) lat++;
            prev_busy = busy;
            if (mv_ack != '0) begin
                int c = 0;
                if ($countones(mv_ack) != 1) multi_ack++;
                for (int k = N - 1; k >= 0; k--) if (mv_ack[k]) c = k;
                obs_ch.push_back(c); obs_err.push_back(int'(mv_err));
                obs_lat.push_back(lat); obs_cyc.push_back(cyc);
                mv_req[c] = 1'b0;
                got++;
            end else if (mv_err) begin
                stray_err++;
            end
        end
        timeout = (got < target);
        mv_req = '0;
        @(negedge CLOCK_50);
        batch_writes = wr_count - w0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLOCK_50);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (mv_ack !== '0) $display("FAIL reset_ack: got %b want 0", mv_ack); else n_pass++;
        n_checks++; if (mv_err !== 1'b0) $display("FAIL reset_err: got %b want 0", mv_err); else n_pass++;
        n_checks++; if (ram_wren !== 1'b0) $display("FAIL reset_wren: got %b want 0", ram_wren); else n_pass++;
        n_checks++; if (ram_addr !== '0) $display("FAIL reset_addr: got %0d want 0", ram_addr); else n_pass++;
        n_checks++; if (ram_wdata !== '0) $display("FAIL reset_wdata: got %h want 0", ram_wdata); else n_pass++;
        reset_n = 1'b1;
    endtask

    task automatic test_basic_move();
        mdl_map[3][6] = int'(PILL);
        reload();
        set_ch(0, 5, 3, 6, 3, int'(PACMAN));
        model_batch(4'b0001);
        run_batch(4'b0001, 40);
        n_checks++; if (timeout || obs_ch.size() != 1) $display("FAIL basic_ack_count: got %0d want 1", obs_ch.size()); else n_pass++;
        n_checks++; if (obs_ch[0] != 0 || obs_err[0] != 0) $display("FAIL basic_ack_chan: got ch %0d err %0d want ch 0 err 0", obs_ch[0], obs_err[0]); else n_pass++;
        n_checks++; if (obs_lat[0] != 7) $display("FAIL basic_latency: got %0d want 7", obs_lat[0]); else n_pass++;
        n_checks++; if (tile_at(3, 5) != int'(EMPTY)) $display("FAIL basic_vacated: got %0d want %0d", tile_at(3, 5), int'(EMPTY)); else n_pass++;
        n_checks++; if (tile_at(3, 6) != int'(PACMAN)) $display("FAIL basic_placed: got %0d want %0d", tile_at(3, 6), int'(PACMAN)); else n_pass++;
        n_checks++; if (batch_writes != 2) $display("FAIL basic_writes: got %0d want 2", batch_writes); else n_pass++;
        // the covered PILL must reappear once pacman leaves
        set_ch(0, 6, 3, 6, 4, int'(PACMAN));
        model_batch(4'b0001);
        run_batch(4'b0001, 40);
        n_checks++; if (tile_at(3, 6) != int'(PILL)) $display("FAIL basic_shadow: got %0d want %0d", tile_at(3, 6), int'(PILL)); else n_pass++;
        n_checks++; if (map_diff() != 0) $display("FAIL basic_map: got %0d differing tiles want 0", map_diff()); else n_pass++;
    endtask

    task automatic test_ghost_pill();
        mdl_map[7][11] = int'(PILL);
        reload();
        set_ch(1, 10, 7, 11, 7, int'(GHOST));
        model_batch(4'b0010);
        run_batch(4'b0010, 40);
        set_ch(1, 11, 7, 12, 7, int'(GHOST));
        model_batch(4'b0010);
        run_batch(4'b0010, 40);
        n_checks++; if (timeout || obs_ch.size() != 1 || obs_ch[0] != 1) $display("FAIL ghost_ack: got %0d acks want 1 on ch 1", obs_ch.size()); else n_pass++;
        n_checks++; if (tile_at(7, 11) != int'(PILL)) $display("FAIL ghost_restore: got %0d want %0d", tile_at(7, 11), int'(PILL)); else n_pass++;
        n_checks++; if (tile_at(7, 12) != int'(GHOST)) $display("FAIL ghost_placed: got %0d want %0d", tile_at(7, 12), int'(GHOST)); else n_pass++;
        n_checks++; if (map_diff() != 0) $display("FAIL ghost_map: got %0d differing tiles want 0", map_diff()); else n_pass++;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int c = 0; c < N; c++) set_ch(c, 2 + 3 * c, 10 + c, 3 + 3 * c, 11 + c, 3 + (c % 2));
        model_batch(4'b1111);
        run_batch(4'b1111, 100);
        n_checks++; if (timeout || obs_ch.size() != 4) $display("FAIL rr_ack_count: got %0d want 4", obs_ch.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (obs_ch[i] != exp_ch[i] || obs_lat[i] != 7) $display("FAIL rr_order[%0d]: got ch %0d lat %0d want ch %0d lat 7", i, obs_ch[i], obs_lat[i], exp_ch[i]); else n_pass++;
        end
        for (int i = 1; i < 4; i++) begin
            n_checks++; if (obs_cyc[i] - obs_cyc[i-1] != 8) $display("FAIL rr_spacing[%0d]: got %0d want 8", i, obs_cyc[i] - obs_cyc[i-1]); else n_pass++;
        end
        n_checks++; if (map_diff() != 0 || batch_writes != 8) $display("FAIL rr_map: got %0d diffs %0d writes want 0 diffs 8 writes", map_diff(), batch_writes); else n_pass++;
    endtask

    task automatic test_error_and_same();
        set_ch(2, 3, 2, 40, 2, int'(GHOST));
        model_batch(4'b0100);
        run_batch(4'b0100, 40);
        n_checks++; if (timeout || obs_ch.size() != 1 || obs_ch[0] != 2) $display("FAIL err_x_ack: got %0d acks want 1 on ch 2", obs_ch.size()); else n_pass++;
        n_checks++; if (obs_err[0] != 1 || stray_err != 0) $display("FAIL err_x_flag: got %0d stray %0d want 1 stray 0", obs_err[0], stray_err); else n_pass++;
        n_checks++; if (batch_writes != 0) $display("FAIL err_x_writes: got %0d want 0", batch_writes); else n_pass++;
        set_ch(2, 3, 30, 4, 2, int'(GHOST));
        model_batch(4'b0100);
        run_batch(4'b0100, 40);
        n_checks++; if (timeout || obs_err.size() != 1 || obs_err[0] != 1 || batch_writes != 0) $display("FAIL err_y: got %0d acks %0d writes want 1 err ack 0 writes", obs_err.size(), batch_writes); else n_pass++;
        set_ch(2, 8, 9, 8, 9, int'(GHOST));
        model_batch(4'b0100);
        run_batch(4'b0100, 40);
        n_checks++; if (timeout || obs_lat.size() != 1 || obs_lat[0] != 1) $display("FAIL same_latency: got %0d want 1", obs_lat[0]); else n_pass++;
        n_checks++; if (obs_err[0] != 0 || batch_writes != 0) $display("FAIL same_nowrite: got err %0d writes %0d want 0 0", obs_err[0], batch_writes); else n_pass++;
        n_checks++; if (map_diff() != 0) $display("FAIL err_map: got %0d differing tiles want 0", map_diff()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int acks = 0, w0, waited = 0;
        mdl_map[5][20] = int'(PILL);
        reload();
        set_ch(3, 19, 5, 20, 5, int'(GHOST));
        model_batch(4'b1000);
        run_batch(4'b1000, 40);
        // aborted move: WR_OLD lands (shadow PILL back at 20,5), nothing after
        set_ch(3, 20, 5, 20, 6, int'(GHOST));
        mdl_map[5][20] = mdl_shadow[3];
        drive_inputs();
        mv_req = 4'b1000;
        while (!busy && waited < 4) begin @(negedge CLOCK_50); waited++; end
        n_checks++; if (!busy) $display("FAIL abort_start: got busy %b want 1", busy); else n_pass++;
        repeat (3) begin @(negedge CLOCK_50); if (mv_ack != '0) acks++; end
        @(posedge CLOCK_50); #2;
        w0 = wr_count;
        reset_n = 1'b0;
        mv_req = '0;
        model_reset();
        #1;
        n_checks++; if (ram_wren !== 1'b0 || busy !== 1'b0 || mv_ack !== '0) $display("FAIL abort_outputs: got wren %b busy %b ack %b want 0 0 0", ram_wren, busy, mv_ack); else n_pass++;
        repeat (2) @(negedge CLOCK_50);
        reset_n = 1'b1;
        repeat (3) begin @(negedge CLOCK_50); if (mv_ack != '0) acks++; end
        n_checks++; if (acks != 0 || wr_count != w0) $display("FAIL abort_quiet: got %0d acks %0d writes want 0 0", acks, wr_count - w0); else n_pass++;
        n_checks++; if (map_diff() != 0) $display("FAIL abort_map: got %0d differing tiles want 0", map_diff()); else n_pass++;
        set_ch(3, 20, 6, 21, 6, int'(GHOST));
        model_batch(4'b1000);
        run_batch(4'b1000, 40);
        n_checks++; if (tile_at(6, 20) != int'(EMPTY)) $display("FAIL abort_shadow: got %0d want %0d", tile_at(6, 20), int'(EMPTY)); else n_pass++;
        n_checks++; if (map_diff() != 0) $display("FAIL abort_after_map: got %0d differing tiles want 0", map_diff()); else n_pass++;
    endtask

    function automatic int rnd_coord(input int lim, input int maxv);
        if ($urandom_range(0, 11) == 0) return int'($urandom_range(lim, maxv));
        return int'($urandom_range(0, lim - 1));
    endfunction

    task automatic test_random();
        for (int b = 0; b < 40; b++) begin
            logic [N-1:0] mask;
            mask = N'($urandom_range(1, 15));
            for (int c = 0; c < N; c++) begin
                set_ch(c, rnd_coord(MW, 63), rnd_coord(MH, 31), rnd_coord(MW, 63), rnd_coord(MH, 31),
                       int'($urandom_range(0, 5)));
                if ($urandom_range(0, 7) == 0) begin ch_nx[c] = ch_cx[c]; ch_ny[c] = ch_cy[c]; end
            end
            model_batch(mask);
            run_batch(mask, 100);
            n_checks++; if (timeout || obs_ch.size() != exp_ch.size() || multi_ack != 0) $display("FAIL rand_acks[%0d]: got %0d acks (multi %0d) want %0d", b, obs_ch.size(), multi_ack, exp_ch.size()); else n_pass++;
            for (int i = 0; i < exp_ch.size() && i < obs_ch.size(); i++) begin
                n_checks++;
                if (obs_ch[i] != exp_ch[i] || obs_err[i] != exp_err[i] || (exp_err[i] == 0 && obs_lat[i] != exp_lat[i]))
                    $display("FAIL rand_move[%0d.%0d]: got ch %0d err %0d lat %0d want ch %0d err %0d lat %0d",
                             b, i, obs_ch[i], obs_err[i], obs_lat[i], exp_ch[i], exp_err[i], exp_lat[i]);
                else n_pass++;
            end
            n_checks++; if (batch_writes != exp_writes || map_diff() != 0 || stray_err != 0) $display("FAIL rand_map[%0d]: got %0d writes %0d diffs want %0d writes 0 diffs", b, batch_writes, map_diff(), exp_writes); else n_pass++;
        end
    endtask

    initial begin
        for (int y = 0; y < MH; y++)
            for (int x = 0; x < MW; x++)
                mdl_map[y][x] = int'($urandom_range(0, 5));
        model_reset();
        for (int c = 0; c < N; c++) set_ch(c, 0, 0, 0, 0, 0);
        reload();
        test_reset();
        test_basic_move();
        test_ghost_pill();
        test_round_robin();
        test_error_and_same();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_map_writer.md
SPRITE_MAP_WRITER -- requirements
Module: sprite_map_writer

Interface
REQ-001 SHALL have parameter N_SPR, default 4: number of sprite channels (pacman plus ghosts).
REQ-002 SHALL have parameter MAP_W, default 40: tiles per map row.
REQ-003 SHALL have parameter MAP_H, default 30: map rows.
REQ-004 SHALL have parameter CODE_W, default 4: bits per tile code; ROW_W = MAP_W*CODE_W, X_W = clog2(MAP_W), Y_W = clog2(MAP_H).
REQ-005 SHALL have ports, clock and reset first:
- CLOCK_50  in  1  system clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- mv_req  in  N_SPR  per-channel move request, level.
- cur_x / nxt_x  in  N_SPR*X_W  current / next tile column per channel.
- cur_y / nxt_y  in  N_SPR*Y_W  current / next tile row per channel.
- spr_code  in  N_SPR*CODE_W  tile code to place at the next position.
- mv_ack  out  N_SPR  one-cycle completion pulse per channel.
- mv_err  out  1  one-cycle pulse with mv_ack when the move was rejected.
- ram_addr  out  Y_W  map RAM row address, shared by read and write.
- ram_wdata  out  ROW_W  row write data.
- ram_wren  out  1  row write enable.
- ram_rdata  in  ROW_W  row read data, 1-cycle read latency.
- busy  out  1  high in every state except IDLE.

Function
REQ-006 Tile x SHALL occupy row bits [ROW_W-1-CODE_W*x -: CODE_W], so column 0 is at the MSBs.
REQ-007 FSM states SHALL be IDLE, RD_OLD, WT_OLD, WR_OLD, RD_NEW, WT_NEW, WR_NEW, DONE.
REQ-008 In IDLE, when any mv_req is high, SHALL grant one channel round-robin, starting after the last granted channel; SHALL latch that channel's cur/nxt/spr_code; SHALL go to RD_OLD.
REQ-009 RD_OLD SHALL drive ram_addr=cur_y. WT_OLD SHALL wait one cycle. WR_OLD SHALL write ram_rdata with tile cur_x replaced by shadow[ch], using ram_addr=cur_y and ram_wren=1.
REQ-010 RD_NEW, WT_NEW and WR_NEW SHALL do the same for nxt_y. In WR_NEW, the replaced tile nxt_x SHALL get spr_code, and the old tile value SHALL be stored in shadow[ch].
REQ-011 DONE SHALL pulse mv_ack[ch] for exactly one cycle and then return to IDLE.
REQ-012 Latency: mv_ack SHALL be high 7 cycles after the granting edge; throughput SHALL be one move per 8 cycles.
REQ-013 ram_wren SHALL be high only in WR_OLD and WR_NEW. ram_addr and ram_wdata SHALL hold their last value otherwise.
REQ-014 If cur equals nxt (both x and y), SHALL skip from IDLE straight to DONE with no RAM writes and shadow unchanged.
REQ-015 If cur_x or nxt_x ≥ MAP_W, or cur_y or nxt_y ≥ MAP_H, SHALL make no writes and SHALL pulse mv_err with mv_ack in DONE.
REQ-016 When cur_y == nxt_y, RD_NEW SHALL re-read the row, so it observes the WR_OLD write.
REQ-017 Request inputs SHALL be ignored after the grant. Dropping mv_req before grant SHALL cancel that request. A requester must deassert mv_req on mv_ack, or it is re-granted.

Reset
REQ-018 reset_n low SHALL immediately force: state=IDLE, ram_wren=0, mv_ack=0, mv_err=0, busy=0, ram_addr=0, ram_wdata=0, round-robin pointer = channel 0 highest priority, all shadow = EMPTY.
REQ-019 Reset mid-operation SHALL abandon the move without ack. A completed WR_OLD is not rolled back.

Structure
REQ-020 Package map_pkg SHALL hold the tile code enum (EMPTY=0, WALL=1, PILL=2, PACMAN=3, GHOST=4, POWER=5) and the MAP_W/MAP_H/CODE_W defaults.
REQ-021 Round-robin selection SHALL be a sub-module rr_arbiter #(N) with inputs req and advance, and a one-hot grant output.

Verification
REQ-022 Channel 0 moves (5,3)->(6,3) with shadow=EMPTY and tile (6,3)=PILL. Required: row 3 tile 5=EMPTY, tile 6=PACMAN, shadow[0]=PILL, mv_ack[0] 7 cycles after grant.
REQ-023 Channel 1 (ghost) steps onto a PILL, then off it. Required: on the second move the PILL is restored at the vacated tile.
REQ-024 mv_req=4'b1111 held, each channel dropped on its ack. Required: grants in order 0,1,2,3, one IDLE cycle between moves, each ack 8 cycles apart.
REQ-025 Channel 2 with nxt_x=40. Required: mv_err and mv_ack[2] pulse, ram_wren never high. Separately, cur==nxt: ack after 1 cycle, no writes.
REQ-026 reset_n asserted in WT_NEW. Required: ram_wren=0 at once, no mv_ack, busy=0; a following move restores EMPTY, not the stale shadow.
